piece_controller: RTL and testbench
===================================

# piece_controller

Generates and moves the active tetromino on the 10x20 playfield. Spawns a pseudo-random piece, proposes gravity, drop, shift and rotate moves as candidate coordinates, and commits the collision-resolved coordinates returned by `block_settling`. Sits directly upstream of `block_settling`: it drives that block's `x*/y*`, `*_next_out`, `movement` and `block_type` inputs and consumes its `changed_*`, `block_logic_reset` and `game_over_logic` outputs.

## Interface
- `LFSR_SEED`, 16'hACE1: LFSR reset value.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: gravity tick, one-cycle pulse.
- `btn_left`, `btn_right`, `btn_rot`, `btn_drop` in 1 each: debounced one-cycle move requests.
- `settle` in 1: level input from `block_logic_reset`.
- `game_over` in 1: from `game_over_logic`.
- `changed_x1..changed_x4` in 4 each; `changed_y1..changed_y4` in 5 each: resolved coordinates.
- `x1..x4` out 4 each; `y1..y4` out 5 each: current piece cells, registered.
- `x1_next_out..x4_next_out` out 4 each; `y1_next_out..y4_next_out` out 5 each: candidate cells, registered.
- `movement` out 3: 000 gravity, 001 drop, 011 left, 100 right, 010 rotate, 111 idle.
- `block_type` out 3: 1..7, 0 only in reset.
- `pieces` out 16: count of spawned pieces.
- `over` out 1: game-over flag.

## Operation
- States: SPAWN, IDLE, PROPOSE, COMMIT, OVER. Reset enters SPAWN.
- Reset values:
  - all `x*`, `y*`, `*_next_out` = 0;
  - `block_type` = 0, `movement` = 111;
  - `pieces` = 0, `over` = 0;
  - `lfsr` = LFSR_SEED, `grav_pend` = 0, `settle_d` = 0.
- LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle except during reset.
- SPAWN:
  - If `game_over` = 1, go to OVER.
  - Otherwise: `block_type` = `lfsr[2:0]`, with 0 mapped to 1; load the spawn shape; set `next_out` = current; `pieces`++; `grav_pend` = 0; go to IDLE.
- Spawn shapes, cells 1..4 as (x,y):
  - 1 I: (3,0)(4,0)(5,0)(6,0)
  - 2 O: (4,0)(5,0)(4,1)(5,1)
  - 3 T: (3,0)(4,0)(5,0)(4,1)
  - 4 S: (4,0)(5,0)(3,1)(4,1)
  - 5 L: (3,0)(4,0)(5,0)(3,1)
  - 6 Z: (3,0)(4,0)(4,1)(5,1)
  - 7 J: (3,0)(4,0)(5,0)(5,1)
- IDLE: choose one request, in priority order `ce`|`grav_pend` > drop > rot > left > right.
  - Gravity and drop: all y+1. Downstream rejects this at the row-20 floor.
  - Left: all x-1. Right: all x+1.
  - Rotate: clockwise about cell 2, x' = x2-(y-y2), y' = y2+(x-x2). Compute in 6-bit signed. O pieces do not rotate.
  - Any candidate x outside 0..9 or y outside 0..19 (rotate, left, right): drop the request and stay in IDLE with `movement` = 111.
  - Otherwise register the candidate into `*_next_out`, set `movement`, clear `grav_pend` if gravity was taken, and go to PROPOSE.
- PROPOSE: outputs held stable for one cycle so the combinational `changed_*` settles. Go to COMMIT.
- COMMIT: `x*/y*` <= `changed_*`; `next_out` <= `changed_*`; `movement` <= 111; go to IDLE.
- A `ce` pulse in SPAWN, PROPOSE or COMMIT sets `grav_pend`. Button pulses outside IDLE are discarded.
- Settle: `settle_d` registers `settle`. A rising edge (`settle` & ~`settle_d`) in IDLE, PROPOSE or COMMIT forces SPAWN next cycle and aborts any pending commit. It overrides all requests.
- OVER: `over` = 1, `movement` = 111, all coordinates frozen, all inputs ignored. Only `reset` exits.
- `pieces` wraps from 16'hFFFF to 0.

## Timing
- A request sampled in IDLE at cycle n gives `movement`/`next_out` valid at n+1 (PROPOSE), `changed_*` sampled at the end of n+2 (COMMIT), and new `x*/y*` visible at n+3.
- Piece move throughput: one move per 3 cycles.
- Settle: rising edge at cycle n gives SPAWN at n+1 and the new piece on the outputs at n+2.
- Reset has priority over everything, including a mid-PROPOSE cycle. The next cycle shows reset values.

## Test plan
- Reset, release, no input: at cycle 2 expect `block_type` = 1, cells (3,0)(4,0)(5,0)(6,0), `pieces` = 1, `movement` = 111.
- I piece at x 3..6, one `ce` with `changed_*` = y+1: expect `movement` = 000 and `y_next` = 1 at n+1, then `y*` = 1 at n+3.
- Piece at x 0..3, `btn_left`: expect no PROPOSE, `movement` stays 111, cells unchanged. `btn_right` instead: x becomes 1..4.
- T piece at (3,5)(4,5)(5,5)(4,6), `btn_rot`: expect candidate (4,4)(4,5)(4,6)(3,5).
- `ce` pulsed during PROPOSE of a left move: expect a gravity proposal immediately after COMMIT, and `grav_pend` cleared.
- `settle` rising during PROPOSE: expect SPAWN, `pieces`++, and no commit of `changed_*`. Holding `settle` high afterwards must not respawn. With `game_over` = 1 at SPAWN: `over` = 1 and outputs frozen until reset.

Source files
------------

// File: rtl/piece_controller.sv
// Active tetromino generator/mover: spawns a pseudo-random piece, proposes
// candidate moves to block_settling and commits the coordinates it resolves.
module piece_controller #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot,
  input  logic        btn_drop,
  input  logic        settle,
  input  logic        game_over,
  input  logic [3:0]  changed_x1, changed_x2, changed_x3, changed_x4,
  input  logic [4:0]  changed_y1, changed_y2, changed_y3, changed_y4,
  output logic [3:0]  x1, x2, x3, x4,
  output logic [4:0]  y1, y2, y3, y4,
  output logic [3:0]  x1_next_out, x2_next_out, x3_next_out, x4_next_out,
  output logic [4:0]  y1_next_out, y2_next_out, y3_next_out, y4_next_out,
  output logic [2:0]  movement,
  output logic [2:0]  block_type,
  output logic [15:0] pieces,
  output logic        over
);
  localparam logic [2:0] MV_GRAV = 3'b000, MV_DROP = 3'b001, MV_ROT = 3'b010,
                         MV_LEFT = 3'b011, MV_RIGHT = 3'b100, MV_IDLE = 3'b111;

  typedef enum logic [2:0] {SPAWN, IDLE, PROPOSE, COMMIT, OVER} state_t;

  state_t            state_q, state_d;
  logic [3:0][3:0]   x_q, x_d, xn_q, xn_d, spawn_x, chg_x;
  logic [3:0][4:0]   y_q, y_d, yn_q, yn_d, spawn_y, chg_y;
  logic [2:0]        mv_q, mv_d, bt_q, bt_d, new_bt, req_mv;
  logic [15:0]       lfsr_q, lfsr_d, pieces_q, pieces_d;
  logic              over_q, over_d, grav_pend_q, grav_pend_d, settle_q;
  logic              settle_rise, cand_ok;
  logic signed [5:0] cx [4];
  logic signed [5:0] cy [4];
  logic signed [5:0] piv_x, piv_y;

  assign chg_x = {changed_x4, changed_x3, changed_x2, changed_x1};
  assign chg_y = {changed_y4, changed_y3, changed_y2, changed_y1};
  assign piv_x = $signed({2'b00, x_q[1]});
  assign piv_y = $signed({1'b0, y_q[1]});
  assign settle_rise = settle & ~settle_q;
  assign new_bt = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];

  always_comb begin
    spawn_x = {4'd6, 4'd5, 4'd4, 4'd3};
    spawn_y = {5'd0, 5'd0, 5'd0, 5'd0};
    case (new_bt)
      3'd2: begin spawn_x = {4'd5, 4'd4, 4'd5, 4'd4}; spawn_y = {5'd1, 5'd1, 5'd0, 5'd0}; end
      3'd3: begin spawn_x = {4'd4, 4'd5, 4'd4, 4'd3}; spawn_y = {5'd1, 5'd0, 5'd0, 5'd0}; end
      3'd4: begin spawn_x = {4'd4, 4'd3, 4'd5, 4'd4}; spawn_y = {5'd1, 5'd1, 5'd0, 5'd0}; end
      3'd5: begin spawn_x = {4'd3, 4'd5, 4'd4, 4'd3}; spawn_y = {5'd1, 5'd0, 5'd0, 5'd0}; end
      3'd6: begin spawn_x = {4'd5, 4'd4, 4'd4, 4'd3}; spawn_y = {5'd1, 5'd1, 5'd0, 5'd0}; end
      3'd7: begin spawn_x = {4'd5, 4'd5, 4'd4, 4'd3}; spawn_y = {5'd1, 5'd0, 5'd0, 5'd0}; end
      default: ;
    endcase
  end

  // Candidate cells for the highest-priority request; side moves and
  // rotations that leave the 10x20 field are refused here.
  always_comb begin
    req_mv = MV_IDLE;
    if (ce || grav_pend_q)  req_mv = MV_GRAV;
    else if (btn_drop)      req_mv = MV_DROP;
    else if (btn_rot)       req_mv = MV_ROT;
    else if (btn_left)      req_mv = MV_LEFT;
    else if (btn_right)     req_mv = MV_RIGHT;
    cand_ok = (req_mv != MV_IDLE) && !(req_mv == MV_ROT && bt_q == 3'd2);
    for (int i = 0; i < 4; i++) begin
      cx[i] = $signed({2'b00, x_q[i]});
      cy[i] = $signed({1'b0, y_q[i]});
      case (req_mv)
        MV_GRAV, MV_DROP: cy[i] = cy[i] + 6'sd1;
        MV_LEFT:          cx[i] = cx[i] - 6'sd1;
        MV_RIGHT:         cx[i] = cx[i] + 6'sd1;
        MV_ROT: begin
          cx[i] = piv_x - ($signed({1'b0, y_q[i]}) - piv_y);
          cy[i] = piv_y + ($signed({2'b00, x_q[i]}) - piv_x);
        end
        default: ;
      endcase
      if ((req_mv == MV_LEFT || req_mv == MV_RIGHT || req_mv == MV_ROT) &&
          (cx[i] < 6'sd0 || cx[i] > 6'sd9 || cy[i] < 6'sd0 || cy[i] > 6'sd19))
        cand_ok = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    xn_d        = xn_q;
    yn_d        = yn_q;
    mv_d        = mv_q;
    bt_d        = bt_q;
    pieces_d    = pieces_q;
    over_d      = over_q;
    grav_pend_d = grav_pend_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      SPAWN: begin
        mv_d = MV_IDLE;
        if (game_over) begin
          over_d  = 1'b1;
          state_d = OVER;
        end else begin
          bt_d        = new_bt;
          x_d         = spawn_x;
          y_d         = spawn_y;
          xn_d        = spawn_x;
          yn_d        = spawn_y;
          pieces_d    = pieces_q + 16'd1;
          grav_pend_d = ce;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        mv_d = MV_IDLE;
        if (settle_rise) begin
          grav_pend_d = grav_pend_q | ce;
          state_d     = SPAWN;
        end else if (cand_ok) begin
          for (int i = 0; i < 4; i++) begin
            xn_d[i] = cx[i][3:0];
            yn_d[i] = cy[i][4:0];
          end
          mv_d = req_mv;
          if (req_mv == MV_GRAV) grav_pend_d = 1'b0;
          state_d = PROPOSE;
        end
      end
      PROPOSE: begin
        grav_pend_d = grav_pend_q | ce;
        if (settle_rise) begin
          mv_d    = MV_IDLE;
          state_d = SPAWN;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        grav_pend_d = grav_pend_q | ce;
        mv_d        = MV_IDLE;
        if (settle_rise) begin
          state_d = SPAWN;
        end else begin
          x_d     = chg_x;
          y_d     = chg_y;
          xn_d    = chg_x;
          yn_d    = chg_y;
          state_d = IDLE;
        end
      end
      default: begin
        mv_d   = MV_IDLE;
        over_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SPAWN;
      x_q         <= '0;
      y_q         <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      mv_q        <= MV_IDLE;
      bt_q        <= 3'd0;
      pieces_q    <= 16'd0;
      over_q      <= 1'b0;
      grav_pend_q <= 1'b0;
      settle_q    <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xn_q        <= xn_d;
      yn_q        <= yn_d;
      mv_q        <= mv_d;
      bt_q        <= bt_d;
      pieces_q    <= pieces_d;
      over_q      <= over_d;
      grav_pend_q <= grav_pend_d;
      settle_q    <= settle;
      lfsr_q      <= lfsr_d;
    end
  end

  assign {x4, x3, x2, x1} = x_q;
  assign {y4, y3, y2, y1} = y_q;
  assign {x4_next_out, x3_next_out, x2_next_out, x1_next_out} = xn_q;
  assign {y4_next_out, y3_next_out, y2_next_out, y1_next_out} = yn_q;
  assign movement   = mv_q;
  assign block_type = bt_q;
  assign pieces     = pieces_q;
  assign over       = over_q;
endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, gravity, shifts, rotation,
// pending gravity, settle abort and game-over freeze.
module tb_piece_controller;
  logic        clk = 1'b0;
  logic        reset, ce, btn_left, btn_right, btn_rot, btn_drop, settle, game_over;
  logic [3:0]  cx1, cx2, cx3, cx4;
  logic [4:0]  cy1, cy2, cy3, cy4;
  logic [3:0]  x1, x2, x3, x4, xn1, xn2, xn3, xn4;
  logic [4:0]  y1, y2, y3, y4, yn1, yn2, yn3, yn4;
  logic [2:0]  movement, block_type;
  logic [15:0] pieces;
  logic        over;
  logic [15:0] m_lfsr;
  logic [2:0]  exp_bt;
  int          tests = 0, fails = 0;

  piece_controller #(.LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .settle(settle), .game_over(game_over),
    .changed_x1(cx1), .changed_x2(cx2), .changed_x3(cx3), .changed_x4(cx4),
    .changed_y1(cy1), .changed_y2(cy2), .changed_y3(cy3), .changed_y4(cy4),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .x1_next_out(xn1), .x2_next_out(xn2), .x3_next_out(xn3), .x4_next_out(xn4),
    .y1_next_out(yn1), .y2_next_out(yn2), .y3_next_out(yn3), .y4_next_out(yn4),
    .movement(movement), .block_type(block_type), .pieces(pieces), .over(over)
  );

  always #5 clk = ~clk;

  // Reference LFSR, used only to know which piece a spawn should produce.
  always @(posedge clk)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  wire [15:0] xs  = {x1, x2, x3, x4};
  wire [19:0] ys  = {y1, y2, y3, y4};
  wire [15:0] xns = {xn1, xn2, xn3, xn4};
  wire [19:0] yns = {yn1, yn2, yn3, yn4};

  function automatic logic [15:0] shape_x(input logic [2:0] t);
    case (t)
      3'd1: return {4'd3, 4'd4, 4'd5, 4'd6};
      3'd2: return {4'd4, 4'd5, 4'd4, 4'd5};
      3'd3: return {4'd3, 4'd4, 4'd5, 4'd4};
      3'd4: return {4'd4, 4'd5, 4'd3, 4'd4};
      3'd5: return {4'd3, 4'd4, 4'd5, 4'd3};
      3'd6: return {4'd3, 4'd4, 4'd4, 4'd5};
      default: return {4'd3, 4'd4, 4'd5, 4'd5};
    endcase
  endfunction

  function automatic logic [19:0] shape_y(input logic [2:0] t);
    case (t)
      3'd1:                return {5'd0, 5'd0, 5'd0, 5'd0};
      3'd2, 3'd4, 3'd6:    return {5'd0, 5'd0, 5'd1, 5'd1};
      default:             return {5'd0, 5'd0, 5'd0, 5'd1};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_chg(input logic [3:0] a, b, c, d, input logic [4:0] e, f, g, h);
    cx1 = a; cx2 = b; cx3 = c; cx4 = d;
    cy1 = e; cy2 = f; cy3 = g; cy4 = h;
  endtask

  initial begin
    reset = 1; ce = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0;
    settle = 0; game_over = 0;
    set_chg(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_xy",     {xs, ys, xns, yns}, 0);
    chk("rst_bt",     block_type, 0);
    chk("rst_mv",     movement, 3'b111);
    chk("rst_pieces", pieces, 0);
    chk("rst_over",   over, 0);

    // Release: first spawn uses the seed, low bits 001 -> I piece.
    reset = 0;
    tick();
    chk("spawn_bt",     block_type, 1);
    chk("spawn_x",      xs, {4'd3, 4'd4, 4'd5, 4'd6});
    chk("spawn_y",      ys, 0);
    chk("spawn_pieces", pieces, 1);
    chk("spawn_mv",     movement, 3'b111);
    chk("spawn_next",   xns, {4'd3, 4'd4, 4'd5, 4'd6});

    // Gravity tick.
    set_chg(3, 4, 5, 6, 1, 1, 1, 1);
    ce = 1; tick(); ce = 0;
    chk("grav_mv",    movement, 3'b000);
    chk("grav_ynext", yns, {5'd1, 5'd1, 5'd1, 5'd1});
    chk("grav_yhold", ys, 0);
    tick();
    chk("grav_prop_hold", movement, 3'b000);
    tick();
    chk("grav_commit_y",  ys, {5'd1, 5'd1, 5'd1, 5'd1});
    chk("grav_commit_mv", movement, 3'b111);

    // Drop, resolved downstream to x 0..3 on row 5.
    set_chg(0, 1, 2, 3, 5, 5, 5, 5);
    btn_drop = 1; tick(); btn_drop = 0;
    chk("drop_mv", movement, 3'b001);
    chk("drop_ynext", yn1, 2);
    tick(); tick();
    chk("drop_commit", {xs, ys}, {4'd0, 4'd1, 4'd2, 4'd3, 5'd5, 5'd5, 5'd5, 5'd5});

    // Left at the wall is refused.
    btn_left = 1; tick(); btn_left = 0;
    chk("left_wall_mv",   movement, 3'b111);
    chk("left_wall_next", xns, {4'd0, 4'd1, 4'd2, 4'd3});
    tick();
    chk("left_wall_x", xs, {4'd0, 4'd1, 4'd2, 4'd3});

    // Right from the wall.
    set_chg(1, 2, 3, 4, 5, 5, 5, 5);
    btn_right = 1; tick(); btn_right = 0;
    chk("right_mv",   movement, 3'b100);
    chk("right_next", xns, {4'd1, 4'd2, 4'd3, 4'd4});
    tick(); tick();
    chk("right_x", xs, {4'd1, 4'd2, 4'd3, 4'd4});

    // Place a T shape via a drop, then rotate it.
    set_chg(3, 4, 5, 4, 5, 5, 5, 6);
    btn_drop = 1; tick(); btn_drop = 0;
    tick(); tick();
    chk("t_place", {xs, ys}, {4'd3, 4'd4, 4'd5, 4'd4, 5'd5, 5'd5, 5'd5, 5'd6});
    set_chg(4, 4, 4, 3, 4, 5, 6, 5);
    btn_rot = 1; tick(); btn_rot = 0;
    chk("rot_mv",    movement, 3'b010);
    chk("rot_cand",  {xns, yns}, {4'd4, 4'd4, 4'd4, 4'd3, 5'd4, 5'd5, 5'd6, 5'd5});
    tick(); tick();

    // ce during PROPOSE of a left move is remembered.
    set_chg(3, 3, 3, 2, 4, 5, 6, 5);
    btn_left = 1; tick(); btn_left = 0;
    chk("pend_left_mv", movement, 3'b011);
    ce = 1; tick(); ce = 0;
    tick();
    chk("pend_left_x",  xs, {4'd3, 4'd3, 4'd3, 4'd2});
    chk("pend_left_mv2", movement, 3'b111);
    set_chg(3, 3, 3, 2, 5, 6, 7, 6);
    tick();
    chk("pend_grav_mv",   movement, 3'b000);
    chk("pend_grav_next", yns, {5'd5, 5'd6, 5'd7, 5'd6});
    tick(); tick();
    chk("pend_grav_y", ys, {5'd5, 5'd6, 5'd7, 5'd6});
    tick();
    chk("pend_cleared", movement, 3'b111);

    // Settle rising during PROPOSE aborts the move and respawns.
    set_chg(9, 9, 9, 9, 9, 9, 9, 9);
    btn_right = 1; tick(); btn_right = 0;
    chk("settle_prop_mv", movement, 3'b100);
    settle = 1; tick();
    exp_bt = (m_lfsr[2:0] == 3'd0) ? 3'd1 : m_lfsr[2:0];
    tick();
    chk("settle_pieces", pieces, 2);
    chk("settle_bt",     block_type, {29'd0, exp_bt});
    chk("settle_shape",  {xs, ys}, {shape_x(exp_bt), shape_y(exp_bt)});
    tick(); tick(); tick();
    chk("settle_hold_pieces", pieces, 2);
    chk("settle_hold_shape",  {xs, ys}, {shape_x(exp_bt), shape_y(exp_bt)});

    // Game over at the next spawn freezes everything.
    settle = 0; tick();
    settle = 1; game_over = 1; tick();
    tick();
    chk("over_flag",   over, 1);
    chk("over_mv",     movement, 3'b111);
    chk("over_pieces", pieces, 2);
    settle = 0; ce = 1; btn_left = 1; btn_drop = 1; tick();
    settle = 1; tick();
    settle = 0; ce = 0; btn_left = 0; btn_drop = 0; tick(); tick();
    chk("over_frozen",  {xs, ys}, {shape_x(exp_bt), shape_y(exp_bt)});
    chk("over_sticky",  over, 1);
    chk("over_pieces2", pieces, 2);
    chk("over_mv2",     movement, 3'b111);

    reset = 1; tick();
    chk("reexit_over",   over, 0);
    chk("reexit_pieces", pieces, 0);
    chk("reexit_bt",     block_type, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
